// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU function codes,
// result flag bit order and a small grant helper.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // Result flags are carried as {cf,zf,vf,sf}.
  localparam int FLAG_CF_POS = 3;
  localparam int FLAG_ZF_POS = 2;
  localparam int FLAG_VF_POS = 1;
  localparam int FLAG_SF_POS = 0;

  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int CNT_W = 16
);

  // Handshake: a request from requester i transfers on a rising edge where
  // req_valid[i] && req_ready[i]; a result transfers where rsp_valid[i] &&
  // rsp_ready[i]. Valid never waits on ready; ready may depend on valid.
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [63:0]      req_a;
  logic [63:0]      req_b;
  logic [9:0]       req_shamt;
  logic [7:0]       req_alufn;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_r;
  logic [3:0]       rsp_flags;
  logic [CNT_W-1:0] op_count;
  logic             dbg_state;

  modport master (
    output req_valid, req_a, req_b, req_shamt, req_alufn, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_flags, op_count, dbg_state
  );

  modport slave (
    input  req_valid, req_a, req_b, req_shamt, req_alufn, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_flags, op_count, dbg_state
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// prv32 combinational ALU: add/sub flags, logic, shifts and set-less-than.
module prv32_ALU
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic [3:0]  alufn,
  output logic [31:0] r,
  output logic        cf,
  output logic        zf,
  output logic        vf,
  output logic        sf
);

  logic        sub;
  logic [31:0] op_b;
  logic [31:0] add;

  always_comb begin
    sub  = alufn[0];
    op_b = sub ? ~b : b;
    {cf, add} = {1'b0, a} + {1'b0, op_b} + {32'b0, sub};
    zf = (add == 32'b0);
    sf = add[31];
    // Carry into the MSB xor carry out of it.
    vf = a[31] ^ op_b[31] ^ add[31] ^ cf;
  end

  always_comb begin
    r = 32'b0;
    case (alufn)
      ALU_ADD,
      ALU_SUB:  r = add;
      ALU_PASS: r = b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> shamt;
      ALU_SLL:  r = a << shamt;
      ALU_SRA:  r = $signed(a) >>> shamt;
      ALU_SLT:  r = {31'b0, sf ^ vf};
      ALU_SLTU: r = {31'b0, ~cf};
      default:  r = 32'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one prv32_ALU between two requesters; one registered result is held
// until its owner consumes it, with back-to-back operation at one per cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR    = 1'b1,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam logic ST_IDLE_ENC = 1'b0;
  localparam logic ST_HOLD_ENC = 1'b1;

  localparam int FLAG_CF = FLAG_CF_POS;
  localparam int FLAG_ZF = FLAG_ZF_POS;
  localparam int FLAG_VF = FLAG_VF_POS;
  localparam int FLAG_SF = FLAG_SF_POS;

  typedef enum logic {
    IDLE = ST_IDLE_ENC,
    HOLD = ST_HOLD_ENC
  } state_t;

  state_t           state;
  logic             owner;
  logic             last_gnt;
  logic [1:0]       rsp_valid_q;
  logic [31:0]      r_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;

  logic             gnt;
  logic             slot_free;
  logic             req_xfer;
  logic             rsp_xfer;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [4:0]       alu_shamt;
  logic [3:0]       alu_fn;
  logic [31:0]      alu_r;
  logic             alu_cf;
  logic             alu_zf;
  logic             alu_vf;
  logic             alu_sf;
  logic [3:0]       alu_flags;

  always_comb begin
    gnt = 1'b0;
    case (bus.req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = RR ? ~last_gnt : 1'b0;
      default: gnt = 1'b0;
    endcase
    // A new request may enter whenever the result register is empty or is
    // being drained in this same cycle.
    slot_free = (state == IDLE) || bus.rsp_ready[owner];
    rsp_xfer  = (state == HOLD) && bus.rsp_ready[owner];
    req_xfer  = !rst && (|bus.req_valid) && slot_free;
  end

  always_comb begin
    alu_a     = gnt ? bus.req_a[63:32]    : bus.req_a[31:0];
    alu_b     = gnt ? bus.req_b[63:32]    : bus.req_b[31:0];
    alu_shamt = gnt ? bus.req_shamt[9:5]  : bus.req_shamt[4:0];
    alu_fn    = gnt ? bus.req_alufn[7:4]  : bus.req_alufn[3:0];
  end

  prv32_ALU u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .shamt (alu_shamt),
    .alufn (alu_fn),
    .r     (alu_r),
    .cf    (alu_cf),
    .zf    (alu_zf),
    .vf    (alu_vf),
    .sf    (alu_sf)
  );

  always_comb begin
    alu_flags          = 4'b0;
    alu_flags[FLAG_CF] = alu_cf;
    alu_flags[FLAG_ZF] = alu_zf;
    alu_flags[FLAG_VF] = alu_vf;
    alu_flags[FLAG_SF] = alu_sf;
  end

  // Pointer resets to requester 1 so that requester 0 wins the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_gnt    <= 1'b1;
      rsp_valid_q <= 2'b00;
      r_q         <= 32'b0;
      flags_q     <= 4'b0;
      cnt_q       <= '0;
    end else begin
      if (rsp_xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (req_xfer) begin
        state       <= HOLD;
        owner       <= gnt;
        last_gnt    <= gnt;
        rsp_valid_q <= grant_onehot(gnt);
        r_q         <= alu_r;
        flags_q     <= alu_flags;
      end else if (rsp_xfer) begin
        state       <= IDLE;
        rsp_valid_q <= 2'b00;
      end
    end
  end

  assign bus.req_ready = req_xfer ? grant_onehot(gnt) : 2'b00;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_r     = r_q;
  assign bus.rsp_flags = flags_q;
  assign bus.op_count  = cnt_q;
  assign bus.dbg_state = state;

endmodule
